// File: rtl/slice_adder_pkg.sv
// adder_pkg: shared types and elaboration helpers for slice_adder.
//   state_t        - controller state (IDLE, BUSY, DONE)
//   calc_nslice()  - number of SLICE-bit slices in a WIDTH-bit word (min 1)
//   slice_cfg_ok() - legal WIDTH/SLICE pairing (WIDTH a positive multiple of SLICE)
package adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int calc_nslice(input int width, input int slice);
        return ((width / slice) < 1) ? 1 : (width / slice);
    endfunction

    function automatic bit slice_cfg_ok(input int width, input int slice);
        return (slice > 0) && (width >= slice) && ((width % slice) == 0);
    endfunction

endpackage

// File: rtl/slice_adder_if.sv
// slice_adder_if: operand and result ports of slice_adder.
//   Input side : in_valid, in_ready, a, b, cin, sub
//   Output side: out_valid, out_ready, sum, cout, ovf
// Handshake: a transfer happens on a rising clock edge where valid and ready are
// both high. The sender holds its payload steady while valid is high. It may not
// make valid depend on ready. The receiver's ready comes from registered state only.
interface slice_adder_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    // master: the client that supplies operands and consumes results
    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    // slave: the adder unit
    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
endinterface

// File: rtl/slice_adder_prefix_slice.sv
// prefix_slice: combinational W-bit adder slice.
//   a, b  : slice operands
//   cin   : carry into bit 0
//   s     : slice sum
//   cout  : carry out of the top bit
//   c_msb : carry into the top bit (used for the signed-overflow flag)
// The carry into each bit is the group generate of all lower bits with cin folded
// in as a bit-(-1) generate. The group terms combine serially from bit 0 upward.
module prefix_slice #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] s,
    output logic         cout,
    output logic         c_msb
);
    logic [W-1:0] g;
    logic [W-1:0] p;
    logic [W:0]   c;

    assign g = a & b;
    assign p = a ^ b;

    always_comb begin
        c    = '0;
        c[0] = cin;
        for (int i = 0; i < W; i++) begin
            c[i+1] = g[i] | (p[i] & c[i]);
        end
    end

    assign s     = p ^ c[W-1:0];
    assign cout  = c[W];
    assign c_msb = c[W-1];
endmodule

// File: rtl/slice_adder.sv
// slice_adder: multi-cycle WIDTH-bit add/subtract unit. It processes one SLICE-bit
// slice per clock and holds the inter-slice carry in a register.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : slice_adder_if slave (operand in / result out handshakes)
//   dbg_state  : current controller state
// Subtraction is done as A + ~B + ~cin. The final carry is reported raw, so in sub
// mode cout=1 means "no borrow".
module slice_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SLICE = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    slice_adder_if.slave    bus,
    output state_t          dbg_state
);
    localparam int NSLICE = calc_nslice(WIDTH, SLICE);
    localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NSLICE - 1);

    generate
        if (!slice_cfg_ok(WIDTH, SLICE)) begin : g_bad_cfg
            $error("slice_adder: WIDTH must be a positive multiple of SLICE");
        end
    endgenerate

    state_t            state_q;
    logic [IDXW-1:0]   idx_q;
    logic              carry_q;
    logic [WIDTH-1:0]  a_q;
    logic [WIDTH-1:0]  b_q;     // already inverted in sub mode
    logic [WIDTH-1:0]  sum_q;
    logic              cout_q;
    logic              ovf_q;

    logic [SLICE-1:0]  sa;
    logic [SLICE-1:0]  sb;
    logic [SLICE-1:0]  ss;
    logic              sc_out;
    logic              sc_msb;

    // The slice index mux is the only logic in front of the slice adder.
    assign sa = a_q[int'(idx_q)*SLICE +: SLICE];
    assign sb = b_q[int'(idx_q)*SLICE +: SLICE];

    prefix_slice #(.W(SLICE)) u_slice (
        .a     (sa),
        .b     (sb),
        .cin   (carry_q),
        .s     (ss),
        .cout  (sc_out),
        .c_msb (sc_msb)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_q     <= bus.a;
                        b_q     <= bus.sub ? ~bus.b : bus.b;
                        carry_q <= bus.cin ^ bus.sub;
                        idx_q   <= '0;
                        state_q <= BUSY;
                    end
                end
                BUSY: begin
                    sum_q[int'(idx_q)*SLICE +: SLICE] <= ss;
                    carry_q <= sc_out;
                    if (idx_q == LAST_IDX) begin
                        // On the top slice, the carry into the word MSB is
                        // c_msb of this slice, so overflow falls out directly.
                        cout_q  <= sc_out;
                        ovf_q   <= sc_msb ^ sc_out;
                        idx_q   <= '0;
                        state_q <= DONE;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
    assign bus.ovf       = ovf_q;
    assign dbg_state     = state_q;
endmodule

// File: tb/tb_slice_adder.sv
module tb_slice_adder;
    import adder_pkg::*;

    logic   clk;
    logic   rst_n;
    state_t dbg_state;
    state_t dbg_state8;

    int checks;
    int errors;

    // expected {ovf, cout, sum}
    logic [33:0] exp_q[$];
    logic [9:0]  exp8_q[$];

    slice_adder_if #(.WIDTH(32)) bus ();
    slice_adder_if #(.WIDTH(8))  bus8 ();

    slice_adder #(.WIDTH(32), .SLICE(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    slice_adder #(.WIDTH(8), .SLICE(8)) dut8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus8),
        .dbg_state (dbg_state8)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference model: plain wide arithmetic with the sign rule for overflow
    function automatic logic [33:0] model32(input logic [31:0] a, input logic [31:0] b,
                                            input logic cin, input logic sub);
        logic [31:0] bb;
        logic        cc;
        logic [32:0] full;
        logic        v;
        bb   = sub ? ~b : b;
        cc   = sub ? ~cin : cin;
        full = {1'b0, a} + {1'b0, bb} + {32'd0, cc};
        v    = (a[31] == bb[31]) && (full[31] != a[31]);
        return {v, full[32], full[31:0]};
    endfunction

    // driver: present operands and wait for acceptance; returns 1 ns after the accept edge
    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic cin,
                        input logic sub, input logic [33:0] exp);
        int n;
        n = 0;
        bus.a = a;
        bus.b = b;
        bus.cin = cin;
        bus.sub = sub;
        bus.in_valid = 1'b1;
        while (!bus.in_ready && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!bus.in_ready) begin
            checks++;
            errors++;
            $display("FAIL send_accept: in_ready=%0b required 1", bus.in_ready);
            bus.in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        exp_q.push_back(exp);
        #1;
        bus.in_valid = 1'b0;
    endtask

    // receiver: wait for a result, compare against the scoreboard, then handshake it out
    task automatic recv(input string name, input int exp_lat);
        int          lat;
        logic [33:0] e;
        lat = 0;
        while (!bus.out_valid && lat < 50) begin
            @(posedge clk);
            #1;
            lat++;
        end
        checks++;
        if (bus.out_valid !== 1'b1) begin
            errors++;
            $display("FAIL %s_timeout: out_valid=%0b required 1", name, bus.out_valid);
            return;
        end
        if (exp_lat >= 0) begin
            checks++;
            if (lat !== exp_lat) begin
                errors++;
                $display("FAIL %s_latency: got %0d required %0d", name, lat, exp_lat);
            end
        end
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s_unexpected: got sum=%h required no result", name, bus.sum);
        end else begin
            e = exp_q.pop_front();
            if ({bus.ovf, bus.cout, bus.sum} !== e) begin
                errors++;
                $display("FAIL %s_result: got sum=%h cout=%0b ovf=%0b required sum=%h cout=%0b ovf=%0b",
                         name, bus.sum, bus.cout, bus.ovf, e[31:0], e[32], e[33]);
            end
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s_release: got in_ready=%0b out_valid=%0b required 1 0",
                     name, bus.in_ready, bus.out_valid);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || dbg_state !== IDLE) begin
            errors++;
            $display("FAIL reset_ctrl: got in_ready=%0b out_valid=%0b state=%0d required 1 0 0",
                     bus.in_ready, bus.out_valid, dbg_state);
        end
        checks++;
        if (bus.sum !== 32'd0 || bus.cout !== 1'b0 || bus.ovf !== 1'b0) begin
            errors++;
            $display("FAIL reset_data: got sum=%h cout=%0b ovf=%0b required 0 0 0",
                     bus.sum, bus.cout, bus.ovf);
        end
        checks++;
        if (bus8.in_ready !== 1'b1 || bus8.out_valid !== 1'b0 || bus8.sum !== 8'd0) begin
            errors++;
            $display("FAIL reset_single: got in_ready=%0b out_valid=%0b sum=%h required 1 0 00",
                     bus8.in_ready, bus8.out_valid, bus8.sum);
        end
    endtask

    task automatic test_directed();
        send(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, {1'b0, 1'b1, 32'h0000_0000});
        recv("add_wrap", 4);
        send(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, {1'b1, 1'b0, 32'h8000_0000});
        recv("add_ovf", 4);
        send(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, {1'b1, 1'b1, 32'h7FFF_FFFF});
        recv("sub_ovf", 4);
        send(32'd5, 32'd7, 1'b1, 1'b1, {1'b0, 1'b0, 32'hFFFF_FFFD});
        recv("sub_borrow", 4);
    endtask

    task automatic test_random();
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic        sub;
        for (int i = 0; i < 16; i++) begin
            a   = $urandom;
            b   = $urandom;
            cin = 1'($urandom_range(0, 1));
            sub = 1'($urandom_range(0, 1));
            // exercise long carry chains across slice borders now and then
            if (i % 4 == 0) b = ~a;
            send(a, b, cin, sub, model32(a, b, cin, sub));
            recv("random", 4);
        end
    endtask

    task automatic test_backpressure();
        logic [33:0] e;
        int          n;
        n = 0;
        send(32'h1234_5678, 32'h0FED_CBA9, 1'b1, 1'b0, {1'b0, 1'b0, 32'h2222_2222});
        while (!bus.out_valid && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        e = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
        bus.a = 32'hDEAD_BEEF;
        bus.b = 32'h0BAD_F00D;
        bus.cin = 1'b1;
        bus.sub = 1'b1;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 ||
                {bus.ovf, bus.cout, bus.sum} !== e) begin
                errors++;
                $display("FAIL bp_hold: cyc %0d got ov=%0b ir=%0b sum=%h cout=%0b ovf=%0b required 1 0 %h %0b %0b",
                         i, bus.out_valid, bus.in_ready, bus.sum, bus.cout, bus.ovf, e[31:0], e[32], e[33]);
            end
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || {bus.ovf, bus.cout, bus.sum} !== e) begin
            errors++;
            $display("FAIL bp_release: got ir=%0b ov=%0b sum=%h required 1 0 %h",
                     bus.in_ready, bus.out_valid, bus.sum, e[31:0]);
        end
        repeat (6) @(posedge clk);
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || dbg_state !== IDLE) begin
            errors++;
            $display("FAIL bp_no_queue: got out_valid=%0b state=%0d required 0 0",
                     bus.out_valid, dbg_state);
        end
    endtask

    task automatic test_reset_mid();
        send(32'hAAAA_AAAA, 32'h5555_5555, 1'b0, 1'b0, {1'b0, 1'b0, 32'hFFFF_FFFF});
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        checks++;
        if (dbg_state !== BUSY) begin
            errors++;
            $display("FAIL mid_busy: got state=%0d required %0d", dbg_state, BUSY);
        end
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_q.delete();
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.sum !== 32'd0) begin
            errors++;
            $display("FAIL mid_reset: got ov=%0b ir=%0b sum=%h required 0 1 00000000",
                     bus.out_valid, bus.in_ready, bus.sum);
        end
        send(32'd3, 32'd4, 1'b0, 1'b0, {1'b0, 1'b0, 32'd7});
        recv("after_reset", 4);
    endtask

    task automatic test_single_slice();
        logic [9:0] e;
        int         lat;
        lat = 0;
        bus8.a = 8'hA5;
        bus8.b = 8'h5A;
        bus8.cin = 1'b1;
        bus8.sub = 1'b0;
        bus8.in_valid = 1'b1;
        @(posedge clk);
        exp8_q.push_back({1'b0, 1'b1, 8'h00});
        #1;
        bus8.in_valid = 1'b0;
        while (!bus8.out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        checks++;
        if (lat !== 1 || bus8.out_valid !== 1'b1) begin
            errors++;
            $display("FAIL single_latency: got %0d (ov=%0b) required 1", lat, bus8.out_valid);
        end
        e = exp8_q.pop_front();
        checks++;
        if ({bus8.ovf, bus8.cout, bus8.sum} !== e) begin
            errors++;
            $display("FAIL single_result: got sum=%h cout=%0b ovf=%0b required sum=%h cout=%0b ovf=%0b",
                     bus8.sum, bus8.cout, bus8.ovf, e[7:0], e[8], e[9]);
        end
        bus8.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus8.out_ready = 1'b0;
        checks++;
        if (bus8.in_ready !== 1'b1 || bus8.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_release: got ir=%0b ov=%0b required 1 0",
                     bus8.in_ready, bus8.out_valid);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        bus.a = '0;
        bus.b = '0;
        bus.cin = 1'b0;
        bus.sub = 1'b0;
        bus.out_ready = 1'b0;
        bus8.in_valid = 1'b0;
        bus8.a = '0;
        bus8.b = '0;
        bus8.cin = 1'b0;
        bus8.sub = 1'b0;
        bus8.out_ready = 1'b0;
        @(posedge clk);
        #1;

        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_reset_mid();
        test_single_slice();

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d results outstanding, required 0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // hard time limit so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/slice_adder.md
# slice_adder

Multi-cycle, parametrised add/subtract unit. It computes a WIDTH-bit sum by passing the operands through one SLICE-bit carry-prefix adder slice per clock cycle, and carries the inter-slice carry in a register. It replaces the fixed 8-bit single-cycle adder where wide operands would otherwise create a long combinational carry path. Operands arrive on a valid/ready input port. Results leave on a valid/ready output port with carry-out and signed-overflow flags.

## Interface
- WIDTH, 32, operand and result width. Must be a multiple of SLICE.
- SLICE, 8, bits added per cycle. NSLICE = WIDTH/SLICE, minimum 1.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset; synchronous and active-low.
- in_valid  in  1  operands valid.
- in_ready  out  1  unit can accept operands.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cin  in  1  carry-in (add) or borrow-in (sub).
- sub  in  1  0 = A+B+cin; 1 = A−B−cin.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- sum  out  WIDTH  result, modulo 2^WIDTH.
- cout  out  1  carry out of the MSB. In sub mode, 1 means no borrow.
- ovf  out  1  two's-complement overflow.

## Operation
- **States:** IDLE, BUSY, DONE.
- **IDLE**
  - in_ready=1.
  - On in_valid&&in_ready: register a, and register b, or ~b if sub=1.
  - Set carry register to cin if sub=0, or to ~cin if sub=1.
  - Set idx=0 and go to BUSY.
- **BUSY**
  - in_ready=0.
  - Each cycle, add slice idx of the registered A and B plus the carry register.
  - Write the SLICE-bit result into sum[idx*SLICE +: SLICE] and update the carry register.
  - When idx==NSLICE−1, also capture the carry into the MSB (c_msb) for the overflow flag, then go to DONE. Otherwise idx++.
- **DONE**
  - out_valid=1. cout = final carry. ovf = c_msb ^ cout.
  - On out_ready, go to IDLE.
- **Arithmetic rules**
  - Subtraction is A + ~B + ~cin.
  - The final carry is reported raw; it is not inverted into a borrow flag.
  - ovf is computed the same way in both modes.
- **Input port**
  - in_valid while in_ready=0 is ignored; nothing is queued.
  - Operands are sampled only on the accept edge, so later changes on a/b/cin/sub have no effect.
- **Output port**
  - sum, cout and ovf are stable for the whole DONE state and while out_ready=0 (backpressure).
  - They keep their last values after returning to IDLE.
- **NSLICE=1:** BUSY lasts exactly one cycle.
- **Reset:** rst_n=0 in any state, including mid-BUSY, gives the following values after that edge:
  - state IDLE, idx 0, carry 0;
  - sum 0, cout 0, ovf 0, out_valid 0, in_ready 1.
  - An operation in flight is discarded.

## Timing
- Acceptance edge t0. Slices are computed at edges t1..tNSLICE.
- out_valid is high from after edge tNSLICE, i.e. a latency of NSLICE cycles.
- The output handshake edge returns the unit to IDLE, so in_ready is high in the next cycle.
- Peak throughput is one operation per NSLICE+2 cycles.
- The combinational critical path is a single SLICE-bit adder plus the mux on the slice index.
- in_ready and out_valid are decoded from registered state only. They have no combinational path from in_valid or out_ready.

## Structure
- **Package adder_pkg**
  - State enum type: IDLE, BUSY, DONE.
  - A function for the slice count (NSLICE).
  - A parameter check that fails elaboration if WIDTH % SLICE != 0.
- **Sub-module prefix_slice**
  - Combinational SLICE-bit adder: generate/propagate signals with a prefix carry chain.
  - Ports: a, b, cin, s, cout, and c_msb (carry into its top bit).
  - Instantiated once, inside the sequential controller slice_adder.

## Test plan
Unless noted, WIDTH=32 and SLICE=8.
- **Add with wrap:** add 0xFFFF_FFFF + 0x0000_0001, cin=0 → sum 0x0000_0000, cout=1, ovf=0; out_valid exactly 4 cycles after the accept edge.
- **Signed add overflow:** add 0x7FFF_FFFF + 0x0000_0001 → 0x8000_0000, cout=0, ovf=1.
- **Subtraction:**
  - sub 0x8000_0000 − 0x0000_0001, cin=0 → 0x7FFF_FFFF, cout=1, ovf=1.
  - sub 5 − 7, cin=1 → 0xFFFF_FFFD, cout=0, ovf=0.
- **Backpressure:** hold out_ready=0 for 10 cycles with in_valid=1 and new operands → sum, cout and ovf unchanged, in_ready=0, and the new operands are never accepted. Raising out_ready gives in_ready=1 on the next cycle.
- **Reset mid-operation:** assert rst_n=0 for one cycle at idx=2 → next cycle out_valid=0, in_ready=1, sum=0. A following add 3+4 → 7.
- **Single-slice build:** WIDTH=8, SLICE=8: add 0xA5 + 0x5A, cin=1 → sum 0x00, cout=1, ovf=0, with 1-cycle latency.
